// File: rtl/core_pkg.sv
// core_pkg: shared ID/EX widths, payload layout, ALU opcodes and stage-state encoding.
package core_pkg;
  localparam int XLEN  = 32;
  localparam int ALU_W = 4;
  localparam int RA_W  = 5;
  typedef struct packed {
    logic             reg_write;
    logic [ALU_W-1:0] alu_ctrl;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [RA_W-1:0]  rd;
  } idex_payload_t;
  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} idex_state_t;
endpackage

// File: rtl/skid_entry_reg.sv
// skid_entry_reg: one valid+payload holding register; clear beats load, payload only changes on load.
module skid_entry_reg import core_pkg::*; #(
  parameter type T = idex_payload_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic ld,
  input  T     d,
  output logic q_valid,
  output T     q
);
  logic r_valid;
  T     r_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= clr ? 1'b0 : (ld ? 1'b1 : r_valid);
      if (ld && !clr) r_data <= d;
    end
  end
  assign q_valid = r_valid;
  assign q       = r_data;
endmodule

// File: rtl/idex_skid_reg.sv
// idex_skid_reg: ID/EX pipeline register with a 2-entry skid buffer, flush and x0 write suppression.
module idex_skid_reg import core_pkg::*; #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int ALU_W = core_pkg::ALU_W,
  parameter int RA_W  = core_pkg::RA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_write_in,
  input  logic [ALU_W-1:0] alu_ctrl_in,
  input  logic [XLEN-1:0]  data1_in,
  input  logic [XLEN-1:0]  data2_in,
  input  logic [RA_W-1:0]  rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write_out,
  output logic [ALU_W-1:0] alu_ctrl_out,
  output logic [XLEN-1:0]  data1_out,
  output logic [XLEN-1:0]  data2_out,
  output logic [RA_W-1:0]  rd_out
);
  typedef struct packed {
    logic             reg_write;
    logic [ALU_W-1:0] alu_ctrl;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [RA_W-1:0]  rd;
  } pl_t;
  pl_t         w_in_pl, w_main_d, w_main_q, w_skid_q;
  logic        w_main_v, w_skid_v, w_accept, w_consume;
  logic        w_ld_main, w_ld_skid, w_clr_main, w_clr_skid, w_main_from_skid;
  logic        r_in_ready;
  idex_state_t w_state, w_nxt;
  assign w_in_pl   = '{reg_write: reg_write_in & (rd_in != '0), alu_ctrl: alu_ctrl_in,
                       data1: data1_in, data2: data2_in, rd: rd_in};
  assign w_main_d  = w_main_from_skid ? w_skid_q : w_in_pl;
  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = w_main_v & out_ready;
  assign w_state   = !w_main_v ? EMPTY : (w_skid_v ? FULL : BUSY);
  always_comb begin
    w_nxt            = w_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_clr_main       = flush;
    w_clr_skid       = flush;
    w_main_from_skid = 1'b0;
    if (flush) w_nxt = EMPTY;
    else
      case (w_state)
        EMPTY: if (w_accept) begin
          w_ld_main = 1'b1;
          w_nxt     = BUSY;
        end
        BUSY: if (w_accept && !w_consume) begin
          w_ld_skid = 1'b1;
          w_nxt     = FULL;
        end else if (w_accept) w_ld_main = 1'b1;
        else if (w_consume) begin
          w_clr_main = 1'b1;
          w_nxt      = EMPTY;
        end
        FULL: if (w_consume) begin
          w_ld_main        = 1'b1;
          w_main_from_skid = 1'b1;
          w_clr_skid       = 1'b1;
          w_nxt            = BUSY;
        end
        default: w_nxt = EMPTY;
      endcase
  end
  // ready is registered from the next state so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_in_ready <= 1'b1;
    else        r_in_ready <= (w_nxt != FULL);
  end
  skid_entry_reg #(.T(pl_t)) u_main (
    .clk(clk), .reset(reset), .clr(w_clr_main), .ld(w_ld_main),
    .d(w_main_d), .q_valid(w_main_v), .q(w_main_q)
  );
  skid_entry_reg #(.T(pl_t)) u_skid (
    .clk(clk), .reset(reset), .clr(w_clr_skid), .ld(w_ld_skid),
    .d(w_in_pl), .q_valid(w_skid_v), .q(w_skid_q)
  );
  assign in_ready      = r_in_ready;
  assign out_valid     = w_main_v;
  assign reg_write_out = w_main_v & w_main_q.reg_write;
  assign alu_ctrl_out  = w_main_q.alu_ctrl;
  assign data1_out     = w_main_q.data1;
  assign data2_out     = w_main_q.data2;
  assign rd_out        = w_main_q.rd;
endmodule

// File: tb/tb_idex_skid_reg.sv
// tb_idex_skid_reg: scoreboard bench for the ID/EX skid register.
module tb_idex_skid_reg;
  import core_pkg::*;
  logic             clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic             in_valid = 1'b0, reg_write_in = 1'b0, out_ready = 1'b0;
  logic [ALU_W-1:0] alu_ctrl_in = '0;
  logic [XLEN-1:0]  data1_in = '0, data2_in = '0;
  logic [RA_W-1:0]  rd_in = '0;
  logic             in_ready, out_valid, reg_write_out;
  logic [ALU_W-1:0] alu_ctrl_out;
  logic [XLEN-1:0]  data1_out, data2_out;
  logic [RA_W-1:0]  rd_out;
  int n_checks = 0, n_fail = 0;
  idex_payload_t q[$];

  idex_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_in(reg_write_in), .alu_ctrl_in(alu_ctrl_in), .data1_in(data1_in),
    .data2_in(data2_in), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_out(reg_write_out), .alu_ctrl_out(alu_ctrl_out), .data1_out(data1_out),
    .data2_out(data2_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit v, input bit rdy, input bit fl, input bit rw,
                       input logic [ALU_W-1:0] alu, input logic [XLEN-1:0] d1,
                       input logic [XLEN-1:0] d2, input logic [RA_W-1:0] rd);
    bit acc;
    idex_payload_t e;
    in_valid = v; out_ready = rdy; flush = fl; reg_write_in = rw;
    alu_ctrl_in = alu; data1_in = d1; data2_in = d2; rd_in = rd;
    acc = v && (q.size() < 2);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) begin
        e = '{rw && (rd != '0), alu, d1, d2, rd};
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, reg_write_out, in_ready, alu_ctrl_out, data1_out, data2_out, rd_out} !==
        {1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 5'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rw=%b rdy=%b alu=%h d1=%h d2=%h rd=%h want all 0, rdy=1",
               out_valid, reg_write_out, in_ready, alu_ctrl_out, data1_out, data2_out, rd_out);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 32'h5, 32'h3, 5'd7);
    n_checks++;
    if ({out_valid, reg_write_out, alu_ctrl_out, rd_out, data1_out, data2_out} !==
        {1'b1, 1'b1, 4'h2, 5'd7, 32'h5, 32'h3}) begin
      n_fail++;
      $display("FAIL basic: got v=%b rw=%b alu=%h rd=%0d d1=%h d2=%h want 1 1 2 7 5 3",
               out_valid, reg_write_out, alu_ctrl_out, rd_out, data1_out, data2_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'(i), 32'h100 + i, 32'h200 + i, 5'(i + 1));
      n_checks++;
      if ({in_ready, out_valid, data1_out, data2_out, rd_out} !==
          {1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 5'(i + 1)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got rdy=%b v=%b d1=%h d2=%h rd=%0d want rdy=1 v=1 d1=%h",
                 i, in_ready, out_valid, data1_out, data2_out, rd_out, 32'h100 + i);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 32'hA, 32'h0, 5'd3);
    n_checks++;
    if ({out_valid, in_ready, data1_out} !== {1'b1, 1'b1, 32'hA}) begin
      n_fail++;
      $display("FAIL stall_a: got v=%b rdy=%b d1=%h want 1 1 a", out_valid, in_ready, data1_out);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 32'hB, 32'h0, 5'd4);
    n_checks++;
    if ({in_ready, out_valid, data1_out} !== {1'b0, 1'b1, 32'hA}) begin
      n_fail++;
      $display("FAIL stall_full: got rdy=%b v=%b d1=%h want 0 1 a", in_ready, out_valid, data1_out);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 32'hD, 32'h0, 5'd5);
    n_checks++;
    if ({in_ready, out_valid, data1_out, rd_out} !== {1'b0, 1'b1, 32'hA, 5'd3}) begin
      n_fail++;
      $display("FAIL stall_hold: got rdy=%b v=%b d1=%h rd=%0d want 0 1 a 3",
               in_ready, out_valid, data1_out, rd_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if ({out_valid, in_ready, data1_out, rd_out} !== {1'b1, 1'b1, 32'hB, 5'd4}) begin
      n_fail++;
      $display("FAIL stall_b: got v=%b rdy=%b d1=%h rd=%0d want 1 1 b 4",
               out_valid, in_ready, data1_out, rd_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if ({out_valid, in_ready, reg_write_out} !== 3'b010) begin
      n_fail++;
      $display("FAIL stall_empty: got v=%b rdy=%b rw=%b want 0 1 0", out_valid, in_ready, reg_write_out);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h11, 32'h22, 5'd0);
    n_checks++;
    if ({out_valid, reg_write_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL x0_rd0: got v=%b rw=%b want v=1 rw=0", out_valid, reg_write_out);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h11, 32'h22, 5'd1);
    n_checks++;
    if ({out_valid, reg_write_out} !== 2'b11) begin
      n_fail++;
      $display("FAIL x0_rd1: got v=%b rw=%b want v=1 rw=1", out_valid, reg_write_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if ({out_valid, reg_write_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_bubble: got v=%b rw=%b want 0 0", out_valid, reg_write_out);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 32'h21, 32'h0, 5'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 32'h22, 32'h0, 5'd6);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_prefull: got rdy=%b want 0", in_ready);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 32'hC, 32'h0, 5'd9);
    n_checks++;
    if ({out_valid, reg_write_out, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush: got v=%b rw=%b rdy=%b want 0 0 1", out_valid, reg_write_out, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      n_checks++;
      if (out_valid !== 1'b0 || data1_out === 32'hC) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: got v=%b d1=%h want v=0 and d1!=c", i, out_valid, data1_out);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'h31, 32'h41, 5'd8);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 32'h32, 32'h42, 5'd9);
    n_checks++;
    if ({out_valid, in_ready, data1_out} !== {1'b1, 1'b0, 32'h31}) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b rdy=%b d1=%h want 1 0 31", out_valid, in_ready, data1_out);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, reg_write_out, alu_ctrl_out, data1_out, data2_out, rd_out} !==
        {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'h0}) begin
      n_fail++;
      $display("FAIL areset_async: got v=%b rw=%b alu=%h d1=%h d2=%h rd=%h want all 0",
               out_valid, reg_write_out, alu_ctrl_out, data1_out, data2_out, rd_out);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL areset_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      n_checks++;
      if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2}) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: got v=%b rdy=%b want v=%b rdy=%b",
                 i, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      n_checks++;
      if (q.size() > 0) begin
        if ({reg_write_out, alu_ctrl_out, data1_out, data2_out, rd_out} !== q[0]) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h want %h", i,
                   {reg_write_out, alu_ctrl_out, data1_out, data2_out, rd_out}, q[0]);
        end
      end else if (reg_write_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_bubble[%0d]: got rw=%b want 0", i, reg_write_out);
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
            1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 5'($urandom));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rand_drain: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
